// File: rtl/fsm_arbiter_pkg.sv
// rtl/fsm_arbiter_pkg.sv - shared state type and default sizes for the arbiter slice
package pck;

    localparam int N_CH_DEF   = 4;
    localparam int WORD_W_DEF = 8;
    localparam int CNT_W_DEF  = 10;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        SHIFT  = 3'd2,
        DRAIN  = 3'd3,
        REPORT = 3'd4
    } arb_state_t;

endpackage

// File: rtl/fsm_arbiter_rr_arbiter.sv
// rtl/fsm_arbiter_rr_arbiter.sv - combinational channel arbiter (round-robin or fixed priority)
//
// Ports:
//   req      in   N_CH  level requests, one bit per channel
//   last_gnt in   IW    index of the previously granted channel
//   gnt      out  N_CH  one-hot winner, all zero when no request
//
// Build option: ARB_STRICT_PRIO_EN selects fixed priority (lowest index wins)
// and last_gnt is ignored; otherwise the search starts just after last_gnt.
module rr_arbiter #(
    parameter int N_CH = 4,
    parameter int IW   = $clog2(N_CH)
) (
    input  logic [N_CH-1:0] req,
    input  logic [IW-1:0]   last_gnt,
    output logic [N_CH-1:0] gnt
);

`ifdef ARB_STRICT_PRIO_EN
    always_comb begin
        gnt = '0;
        // Walk downward so the lowest asserted index is the last one written.
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (req[i]) begin
                gnt    = '0;
                gnt[i] = 1'b1;
            end
        end
    end
`else
    logic [IW-1:0] idx;
    logic          found;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        // N_CH is a power of two, so the IW-bit add wraps modulo N_CH;
        // offset N_CH lands back on last_gnt itself as the final candidate.
        for (int i = 1; i <= N_CH; i++) begin
            idx = last_gnt + IW'(i);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/fsm_arbiter.sv
// rtl/fsm_arbiter.sv - grants one requester at a time and streams its word through the shared detector
//
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   req        per-channel level request
//   data_in    per-channel word, channel i at [i*WORD_W +: WORD_W]
//   gnt        one-hot single-cycle grant; the granted word is captured that cycle
//   det_x      serial bit to the detector, MSB first
//   det_rst    detector reset (rst or CLEAR state)
//   det_y      detector output, sampled one cycle after each bit
//   busy       high outside IDLE
//   done       single-cycle pulse in REPORT
//   done_id    channel served, held until the next done
//   hit_cnt    detector hits in the served word, held until the next done
//   tot_cnt    running hit total, wraps silently
//
// Build option: ARB_STRICT_PRIO_EN switches the arbiter to fixed priority.
module fsm_arbiter
    import pck::*;
#(
    parameter int N_CH   = N_CH_DEF,
    parameter int WORD_W = WORD_W_DEF,
    parameter int CNT_W  = CNT_W_DEF,
    parameter int IW     = $clog2(N_CH),
    parameter int HW     = $clog2(WORD_W) + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_CH-1:0]        req,
    input  logic [N_CH*WORD_W-1:0] data_in,
    output logic [N_CH-1:0]        gnt,
    output logic                   det_x,
    output logic                   det_rst,
    input  logic                   det_y,
    output logic                   busy,
    output logic                   done,
    output logic [IW-1:0]          done_id,
    output logic [HW-1:0]          hit_cnt,
    output logic [CNT_W-1:0]       tot_cnt
);

    localparam int BW = $clog2(WORD_W);

    arb_state_t         state_q,    state_d;
    logic [WORD_W-1:0]  word_q,     word_d;
    logic [IW-1:0]      id_q,       id_d;
    logic [IW-1:0]      last_gnt_q, last_gnt_d;
    logic [IW-1:0]      done_id_q,  done_id_d;
    logic [BW-1:0]      bit_q,      bit_d;
    logic [HW-1:0]      acc_q,      acc_d;
    logic [HW-1:0]      hit_q,      hit_d;
    logic [CNT_W-1:0]   tot_q,      tot_d;

    logic [N_CH-1:0]    arb_gnt;
    logic [IW-1:0]      arb_id;
    logic [BW-1:0]      sh_idx;

    rr_arbiter #(
        .N_CH (N_CH),
        .IW   (IW)
    ) u_arb (
        .req      (req),
        .last_gnt (last_gnt_q),
        .gnt      (arb_gnt)
    );

    always_comb begin
        arb_id = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (arb_gnt[i]) arb_id = IW'(i);
        end
    end

    // bit_q counts SHIFT cycles from 0, so the MSB goes out first.
    assign sh_idx = BW'(WORD_W - 1) - bit_q;

    always_comb begin
        state_d    = state_q;
        word_d     = word_q;
        id_d       = id_q;
        last_gnt_d = last_gnt_q;
        done_id_d  = done_id_q;
        bit_d      = bit_q;
        acc_d      = acc_q;
        hit_d      = hit_q;
        tot_d      = tot_q;
        gnt        = '0;
        det_x      = 1'b0;
        done       = 1'b0;

        case (state_q)
            IDLE: begin
                if (|req) begin
                    gnt        = arb_gnt;
                    word_d     = data_in[arb_id*WORD_W +: WORD_W];
                    id_d       = arb_id;
                    last_gnt_d = arb_id;
                    state_d    = CLEAR;
                end
            end
            CLEAR: begin
                acc_d   = '0;
                bit_d   = '0;
                state_d = SHIFT;
            end
            SHIFT: begin
                det_x = word_q[sh_idx];
                // In the first SHIFT cycle det_y still reflects the detector reset.
                if (bit_q != '0 && det_y) acc_d = acc_q + HW'(1);
                if (bit_q == BW'(WORD_W - 1)) begin
                    state_d = DRAIN;
                end else begin
                    bit_d = bit_q + BW'(1);
                end
            end
            DRAIN: begin
                // Last sample belongs to the final bit; publish the result for REPORT.
                hit_d     = acc_q + {{(HW-1){1'b0}}, det_y};
                done_id_d = id_q;
                state_d   = REPORT;
            end
            REPORT: begin
                done    = 1'b1;
                tot_d   = tot_q + CNT_W'(hit_q);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Reset overrides the combinational pulses in the same cycle.
        if (rst) begin
            gnt   = '0;
            det_x = 1'b0;
            done  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            word_q     <= '0;
            id_q       <= '0;
            last_gnt_q <= IW'(N_CH - 1);
            done_id_q  <= '0;
            bit_q      <= '0;
            acc_q      <= '0;
            hit_q      <= '0;
            tot_q      <= '0;
        end else begin
            state_q    <= state_d;
            word_q     <= word_d;
            id_q       <= id_d;
            last_gnt_q <= last_gnt_d;
            done_id_q  <= done_id_d;
            bit_q      <= bit_d;
            acc_q      <= acc_d;
            hit_q      <= hit_d;
            tot_q      <= tot_d;
        end
    end

    assign busy    = !rst && (state_q != IDLE);
    assign det_rst = rst || (state_q == CLEAR);
    assign done_id = done_id_q;
    assign hit_cnt = hit_q;
    assign tot_cnt = tot_q;

endmodule

// File: tb/tb_fsm_arbiter.sv
// tb/tb_fsm_arbiter.sv - randomized scoreboard bench for fsm_arbiter with a 101 sequence detector model
module tb_fsm_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int CW = 10;
    localparam int IW = 2;
    localparam int HW = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req = '0;
    logic [N*W-1:0]  data_in = '0;
    logic            det_y = 1'b0;
    logic [N-1:0]    gnt;
    logic            det_x, det_rst, busy, done;
    logic [IW-1:0]   done_id;
    logic [HW-1:0]   hit_cnt;
    logic [CW-1:0]   tot_cnt;

    fsm_arbiter #(.N_CH(N), .WORD_W(W), .CNT_W(CW)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .data_in (data_in),
        .gnt     (gnt),
        .det_x   (det_x),
        .det_rst (det_rst),
        .det_y   (det_y),
        .busy    (busy),
        .done    (done),
        .done_id (done_id),
        .hit_cnt (hit_cnt),
        .tot_cnt (tot_cnt)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    logic force_y = 1'b0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Detector: registered Moore output, high when the last three bits were 1,0,1.
    logic [2:0] hist = '0;
    always @(posedge clk) begin
        logic xs, rs;
        xs = det_x;
        rs = det_rst;
        #1;
        if (rs) begin
            hist  = '0;
            det_y = force_y;
        end else begin
            hist  = {hist[1:0], xs};
            det_y = force_y | (hist == 3'b101);
        end
    end

    // Reference model
    typedef struct {
        int         id;
        logic [W-1:0] word;
        int         hits;
        int         tot;
        int         gcyc;
    } rec_t;

    rec_t gnt_q[$];
    rec_t done_q[$];
    int   gnt_order[$];
    int   m_last = N - 1;
    int   m_rem  = 0;
    int   m_tot  = 0;
    logic [W-1:0] m_word = '0;

    function automatic int winner(input logic [N-1:0] r, input int last);
`ifdef ARB_STRICT_PRIO_EN
        for (int i = 0; i < N; i++) if (r[i]) return i + 0 * last;
`else
        for (int k = 1; k <= N; k++) if (r[(last + k) % N]) return (last + k) % N;
`endif
        return -1;
    endfunction

    // Bits go out MSB first from a cleared detector; a hit is seen after
    // every bit that completes the pattern 1,0,1.
    function automatic int hits_of(input logic [W-1:0] w, input logic fy);
        int n;
        logic [W-1:0] b;
        if (fy) return W;
        n = 0;
        for (int k = 0; k < W; k++) b[k] = w[W-1-k];
        for (int k = 2; k < W; k++) if (b[k-2] && !b[k-1] && b[k]) n++;
        return n;
    endfunction

    always @(negedge clk) begin
        rec_t r;
        int   d;
        int   w;
        if (rst) begin
            gnt_q.delete();
            done_q.delete();
            m_rem  = 0;
            m_last = N - 1;
            m_tot  = 0;
        end else if (m_rem > 0) begin
            d = W + 4 - m_rem;
            chk("busy", busy, 1);
            chk("det_rst_busy", det_rst, (d == 1) ? 1 : 0);
            chk("det_x", det_x, (d >= 2 && d <= W + 1) ? m_word[W-1-(d-2)] : 1'b0);
            m_rem--;
        end else begin
            chk("busy_idle", busy, 0);
            chk("det_rst_idle", det_rst, 0);
            if (req != '0) begin
                w      = winner(req, m_last);
                r.id   = w;
                r.word = data_in[w*W +: W];
                r.hits = hits_of(r.word, force_y);
                m_tot  = (m_tot + r.hits) % (1 << CW);
                r.tot  = m_tot;
                r.gcyc = cyc;
                gnt_q.push_back(r);
                done_q.push_back(r);
                gnt_order.push_back(w);
                m_last = w;
                m_word = r.word;
                m_rem  = W + 3;
            end
        end
    end

    // Monitor
    int tot_pending = 0;
    int tot_exp     = 0;
    always @(negedge clk) begin
        rec_t r;
        #1;
        if (gnt != '0) begin
            if (gnt_q.size() == 0) begin
                chk("gnt_unexpected", gnt, 0);
            end else begin
                r = gnt_q.pop_front();
                chk("gnt_onehot", gnt, 64'(1) << r.id);
                chk("gnt_cycle", cyc, r.gcyc);
            end
        end
        if (done) begin
            if (done_q.size() == 0) begin
                chk("done_unexpected", done, 0);
            end else begin
                r = done_q.pop_front();
                chk("done_latency", cyc - r.gcyc, W + 3);
                chk("done_id", done_id, r.id);
                chk("hit_cnt", hit_cnt, r.hits);
                tot_exp     = r.tot;
                tot_pending = 1;
            end
        end else if (tot_pending != 0) begin
            chk("tot_cnt", tot_cnt, tot_exp);
            tot_pending = 0;
        end
    end

    task automatic wait_done(input int limit);
        int n;
        n = 0;
        @(negedge clk);
        while (!done && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (!done) chk("done_timeout", 0, 1);
    endtask

    task automatic do_reset(input int n);
        @(posedge clk); #2;
        rst = 1'b1;
        req = '0;
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_gnt", gnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_done_id", done_id, 0);
        chk("rst_hit_cnt", hit_cnt, 0);
        chk("rst_tot_cnt", tot_cnt, 0);
        chk("rst_det_x", det_x, 0);
        chk("rst_det_rst", det_rst, 1);

        // Single request on ch2 with A5
        @(posedge clk); #2;
        rst     = 1'b0;
        data_in = {$urandom, $urandom};
        data_in[2*W +: W] = 8'hA5;
        req     = 4'b0100;
        @(negedge clk);
        chk("a5_gnt", gnt, 4'b0100);
        @(posedge clk); #2;
        req = '0;
        wait_done(30);
        chk("a5_done_id", done_id, 2);
        chk("a5_hit_cnt", hit_cnt, 2);
        repeat (2) @(posedge clk);

        // All requesting for four words from reset
        do_reset(2);
        gnt_order.delete();
        rst = 1'b0;
        req = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            wait_done(30);
            @(posedge clk); #2;
            data_in = {$urandom, $urandom};
        end
        req = '0;
        for (int i = 0; i < 4; i++) begin
`ifdef ARB_STRICT_PRIO_EN
            chk("order", (gnt_order.size() > i) ? gnt_order[i] : -1, 0);
`else
            chk("order", (gnt_order.size() > i) ? gnt_order[i] : -1, i);
`endif
        end
        repeat (2) @(posedge clk);

        // Reset in the 5th SHIFT cycle
        @(posedge clk); #2;
        req = 4'b0001;
        @(posedge clk); #2;
        req = '0;
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b1;
        req = 4'b1111;
        @(posedge clk); #2;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_gnt", gnt, 4'b0001);
        chk("abort_done_id", done_id, 0);
        chk("abort_hit_cnt", hit_cnt, 0);
        chk("abort_tot_cnt", tot_cnt, 0);
        chk("abort_done", done, 0);
        chk("abort_det_x", det_x, 0);
        @(posedge clk); #2;
        req = '0;
        wait_done(30);
        repeat (2) @(posedge clk);

        // Random requests and data toggling in every cycle, busy or not
        for (int i = 0; i < 600; i++) begin
            @(posedge clk); #2;
            req     = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom);
            data_in = {$urandom, $urandom};
        end
        req = '0;
        repeat (W + 6) @(posedge clk);

        // det_y stuck high: 128 words of 8 hits wrap tot_cnt
        do_reset(2);
        force_y = 1'b1;
        rst     = 1'b0;
        req     = 4'b1111;
        for (int i = 0; i < 128; i++) begin
            wait_done(30);
            if (i == 0) chk("forced_hit_cnt", hit_cnt, W);
            @(posedge clk); #2;
            data_in = {$urandom, $urandom};
        end
        req = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("tot_wrap", tot_cnt, 0);
        chk("gnt_q_drained", gnt_q.size(), 0);
        chk("done_q_drained", done_q.size(), 0);
        force_y = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout actual=%0d required=0", cyc);
        $fatal(1);
    end

endmodule

// File: doc/fsm_arbiter.md
FSM_ARBITER -- requirements
Module: fsm_arbiter

Interface
REQ-001 Parameter N_CH, default 4: number of requester channels (power of two, 2..8).
REQ-002 Parameter WORD_W, default 8: bits per request word.
REQ-003 Parameter CNT_W, default 10: width of the total hit counter.
REQ-004 One clock; reset is synchronous and active-high.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 req  input  N_CH  per-channel level request, one bit per channel.
REQ-008 data_in  input  N_CH*WORD_W  per-channel word; channel i occupies bits [i*WORD_W +: WORD_W].
REQ-009 gnt  output  N_CH  one-hot, single-cycle pulse; the word of the granted channel is captured in that cycle.
REQ-010 det_x  output  1  serial bit to the shared detector FSM x input.
REQ-011 det_rst  output  1  reset to the shared detector: rst OR (state == CLEAR).
REQ-012 det_y  input  1  detector output y.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 done  output  1  single-cycle pulse in REPORT.
REQ-015 done_id  output  $clog2(N_CH)  channel served; valid while done=1 and held until the next done.
REQ-016 hit_cnt  output  $clog2(WORD_W)+1  hits in the served word; valid while done=1 and held.
REQ-017 tot_cnt  output  CNT_W  running total of hits across all words.

Function
REQ-018 States: IDLE, CLEAR, SHIFT, DRAIN, REPORT.
REQ-019 IDLE: when any req bit is 1, pulse gnt for the arbitration winner, latch its word and id, and go to CLEAR. With no request, remain in IDLE.
REQ-020 CLEAR lasts 1 cycle with det_rst=1 and det_x=0, then goes to SHIFT.
REQ-021 SHIFT lasts exactly WORD_W cycles; det_x = word bit [WORD_W-1-k] in the k-th SHIFT cycle (MSB first). It then goes to DRAIN.
REQ-022 DRAIN lasts 1 cycle with det_x=0, then goes to REPORT.
REQ-023 hit_cnt increments when det_y=1 in SHIFT cycles 2..WORD_W and in DRAIN, giving exactly WORD_W samples, each one cycle after its bit. det_y is ignored in all other states.
REQ-024 REPORT lasts 1 cycle with done=1; tot_cnt += hit_cnt of the word, wrapping modulo 2^CNT_W; then goes to IDLE.
REQ-025 Latency from gnt to done is WORD_W+3 cycles (11 at the default). The next gnt comes no earlier than 1 cycle after done.
REQ-026 Changes to req or data_in while busy=1 are ignored. The latched word is immutable until REPORT.
REQ-027 A requester that holds req high after its gnt is treated as a new request at the next IDLE.
REQ-028 Default arbitration is round-robin: search starts at (last_gnt+1) mod N_CH, and the first asserted req wins.
REQ-029 hit_cnt saturation cannot occur (max WORD_W). tot_cnt wrap from 2^CNT_W-1 goes to the residual value with no flag.

Reset
REQ-030 On rst=1: state=IDLE, gnt=0, busy=0, done=0, done_id=0, hit_cnt=0, tot_cnt=0, det_x=0, last_gnt=N_CH-1 (so channel 0 wins first), det_rst=1.
REQ-031 rst mid-operation aborts the word with no done and no gnt. The first grant is possible in the cycle after rst deasserts.

Configuration
REQ-032 Macro ARB_STRICT_PRIO_EN: when defined, arbitration is fixed priority with the lowest asserted index winning, and last_gnt is unused. When undefined, REQ-028 round-robin applies.

Structure
REQ-033 Package pck holds the state enum typedef (arb_state_t) and default constants N_CH_DEF, WORD_W_DEF, CNT_W_DEF.
REQ-034 One sub-module, rr_arbiter (req, last_gnt -> one-hot gnt), contains both arbitration modes under ARB_STRICT_PRIO_EN.

Verification
REQ-035 Bench drives det_y from a reference model of the detector. Scenarios:
REQ-036 Only req[2] with data 8'hA5 -> gnt=4'b0100, det_x sequence 1,0,1,0,0,1,0,1, done 11 cycles after gnt, done_id=2.
REQ-037 req=4'b1111 held for 4 words -> gnt order ch0,ch1,ch2,ch3 (with ARB_STRICT_PRIO_EN: ch0 four times).
REQ-038 det_y forced to 1 throughout -> hit_cnt=8 and tot_cnt +8 per word; 128 words from reset -> tot_cnt wraps to 0.
REQ-039 rst pulsed in the 5th SHIFT cycle -> no done, all outputs at reset values, next req granted to ch0 in the cycle after rst falls.
REQ-040 data_in and req toggled randomly while busy=1 -> captured word and done_id unchanged; no gnt until after done.
